// File: rtl/keypad_pkg.sv
// Shared types for the matrix keypad scanner.
// State and frame-result encodings plus a width helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } result_e;

  function automatic int code_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_frame_scanner.sv
// Column walker: drives one column low at a time, samples rows
// at the end of each settle window, classifies the whole frame.
module keypad_frame_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE_CYC = 4,
  parameter int CODE_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic              frame_done,
  output result_e           frame_res,
  output logic [CODE_W-1:0] frame_code
);

  localparam int SW = code_w(SETTLE_CYC);
  localparam int IW = code_w(COLS);
  localparam logic [COLS-1:0] ONE = COLS'(1);

  logic [IW-1:0]     idx_q;
  logic [SW-1:0]     settle_q;
  logic [1:0]        hits_q, hits_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              done_q;
  result_e           res_q;
  logic [CODE_W-1:0] fcode_q;
  logic              last_set, last_col;

  assign col        = rst ? '1 : ~(ONE << idx_q);
  assign frame_done = done_q;
  assign frame_res  = res_q;
  assign frame_code = fcode_q;

  assign last_set = settle_q == SW'(SETTLE_CYC - 1);
  assign last_col = idx_q == IW'(COLS - 1);

  // Hit count saturates at 2: anything beyond one key is ghost-prone.
  always_comb begin
    hits_d = hits_q;
    code_d = code_q;
    for (int r = 0; r < ROWS; r++) begin
      if (!row[r]) begin
        if (hits_d != 2'd2) hits_d = hits_d + 2'd1;
        code_d = CODE_W'(r * COLS + int'(idx_q));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      settle_q <= '0;
      hits_q   <= '0;
      code_q   <= '0;
      done_q   <= 1'b0;
      res_q    <= RES_NONE;
      fcode_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!last_set) begin
        settle_q <= settle_q + 1'b1;
      end else begin
        settle_q <= '0;
        if (last_col) begin
          idx_q   <= '0;
          hits_q  <= '0;
          code_q  <= '0;
          done_q  <= 1'b1;
          fcode_q <= code_d;
          res_q   <= (hits_d == 2'd0) ? RES_NONE :
                     (hits_d == 2'd1) ? RES_SINGLE : RES_MULTI;
        end else begin
          idx_q  <= idx_q + 1'b1;
          hits_q <= hits_d;
          code_q <= code_d;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad controller: frame scanner plus per-frame
// debounce, release and auto-repeat event FSM.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE_CYC = 50000,
  parameter int DEB_FRAMES = 5,
  parameter int REPEAT_EN  = 1,
  parameter int REPEAT_DLY = 125,
  parameter int REPEAT_PER = 25,
  localparam int CODE_W    = code_w(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic              key_valid,
  output logic              key_repeat,
  output logic              key_release,
  output logic [CODE_W-1:0] key_code,
  output logic              key_down
);

  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW = code_w(DEB_FRAMES + 1);
  localparam int RW = code_w(RPT_MAX + 1);
  localparam logic [CW-1:0] DEB_L = CW'(DEB_FRAMES);
  localparam logic [RW-1:0] DLY_L = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] PER_L = RW'(REPEAT_PER);

  logic              frame_done;
  result_e           frame_res;
  logic [CODE_W-1:0] frame_code;

  state_e            state_q;
  logic [CODE_W-1:0] cand_q, code_q;
  logic [CW-1:0]     cnt_q, rel_q;
  logic [RW-1:0]     rpt_q;
  logic              first_q;
  logic              valid_q, repeat_q, release_q, down_q;
  logic              hit, same_cand, match, accept;
  logic [RW-1:0]     rpt_nx, rpt_tgt;

  keypad_frame_scanner #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SETTLE_CYC (SETTLE_CYC),
    .CODE_W     (CODE_W)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .frame_done (frame_done),
    .frame_res  (frame_res),
    .frame_code (frame_code)
  );

  assign hit       = frame_res == RES_SINGLE;
  assign same_cand = hit && (frame_code == cand_q);
  assign match     = hit && (frame_code == code_q);
  assign rpt_nx    = rpt_q + 1'b1;
  assign rpt_tgt   = first_q ? DLY_L : PER_L;
  assign accept    = frame_done &&
    ((state_q == ST_IDLE && hit && DEB_FRAMES == 1) ||
     (state_q == ST_DEBOUNCE && same_cand && (cnt_q + 1'b1) == DEB_L));

  assign key_valid   = valid_q;
  assign key_repeat  = repeat_q;
  assign key_release = release_q;
  assign key_code    = code_q;
  assign key_down    = down_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cand_q    <= '0;
      code_q    <= '0;
      cnt_q     <= '0;
      rel_q     <= '0;
      rpt_q     <= '0;
      first_q   <= 1'b0;
      valid_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      if (accept) begin
        valid_q <= 1'b1;
        code_q  <= frame_code;
        down_q  <= 1'b1;
        state_q <= ST_HELD;
        rel_q   <= '0;
        rpt_q   <= '0;
        first_q <= 1'b1;
      end else if (frame_done) begin
        unique case (1'b1)
          state_q == ST_IDLE: begin
            if (hit) begin
              cand_q  <= frame_code;
              cnt_q   <= CW'(1);
              state_q <= ST_DEBOUNCE;
            end
          end
          state_q == ST_DEBOUNCE: begin
            if (same_cand) begin
              cnt_q <= cnt_q + 1'b1;
            end else if (hit) begin
              cand_q <= frame_code;
              cnt_q  <= CW'(1);
            end else begin
              state_q <= ST_IDLE;
            end
          end
          state_q == ST_HELD: begin
            if (match) begin
              // A matching frame cancels a pending release only.
              rel_q <= '0;
              if (REPEAT_EN != 0) begin
                if (rpt_nx == rpt_tgt) begin
                  valid_q  <= 1'b1;
                  repeat_q <= 1'b1;
                  rpt_q    <= '0;
                  first_q  <= 1'b0;
                end else begin
                  rpt_q <= rpt_nx;
                end
              end
            end else if ((rel_q + 1'b1) == DEB_L) begin
              release_q <= 1'b1;
              down_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              rel_q <= rel_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed frame-vector bench for keypad_scan_ctrl
// (4x4, settle 4, debounce 3, repeat 6/2).
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row, col;
  logic        key_valid, key_repeat, key_release, key_down;
  logic [3:0]  key_code;
  logic [15:0] mask = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_viol = 0;

  localparam logic [15:0] K6  = 16'h0040;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K05 = 16'h0021;
  localparam logic [15:0] K69 = 16'h0240;

  typedef struct {
    logic [15:0] mask;
    int v;
    int rep;
    int rel;
    int down;
    int code;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .ROWS       (4),
    .COLS       (4),
    .SETTLE_CYC (4),
    .DEB_FRAMES (3),
    .REPEAT_EN  (1),
    .REPEAT_DLY (6),
    .REPEAT_PER (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .key_valid   (key_valid),
    .key_repeat  (key_repeat),
    .key_release (key_release),
    .key_code    (key_code),
    .key_down    (key_down)
  );

  // Keypad model: a pressed switch shorts its column onto its row.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && mask[r*4+c]) row[r] = 1'b0;
  end

  always @(negedge clk)
    if ((key_repeat && !key_valid) || (key_valid && key_release))
      n_viol++;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic void push(input int n, input logic [15:0] m,
                               input int v, input int rep, input int rel,
                               input int down, input int code);
    vec_t t;
    t.mask = m; t.v = v; t.rep = rep; t.rel = rel;
    t.down = down; t.code = code;
    for (int i = 0; i < n; i++) tbl.push_back(t);
  endfunction

  // One frame window: starts two cycles into a frame, so the
  // pulse caused by this frame lands on its last sample.
  task automatic apply(input vec_t t, input string nm);
    int nv = 0, nrel = 0, rep_at = 0, code_at = 0;
    int l_down = 0, l_code = 0;
    mask = t.mask;
    for (int j = 0; j < 16; j++) begin
      if (key_valid) begin
        nv++;
        rep_at  = int'(key_repeat);
        code_at = int'(key_code);
      end
      if (key_release) nrel++;
      if (j == 15) begin
        l_down = int'(key_down);
        l_code = int'(key_code);
      end
      @(negedge clk);
    end
    chk({nm, " valid"}, nv, t.v);
    chk({nm, " release"}, nrel, t.rel);
    chk({nm, " down"}, l_down, t.down);
    chk({nm, " code"}, l_code, t.code);
    if (t.v != 0) begin
      chk({nm, " repeat"}, rep_at, t.rep);
      chk({nm, " vcode"}, code_at, t.code);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t t6;
    int   nrel;
    // press/release of key 6
    push(2, K6, 0, 0, 0, 0, 0);
    push(1, K6, 1, 0, 0, 1, 6);
    push(2, '0, 0, 0, 0, 1, 6);
    push(1, '0, 0, 0, 1, 0, 6);
    // press bounce
    push(2, K6, 0, 0, 0, 0, 6);
    push(1, '0, 0, 0, 0, 0, 6);
    push(2, K6, 0, 0, 0, 0, 6);
    push(1, K6, 1, 0, 0, 1, 6);
    push(2, '0, 0, 0, 0, 1, 6);
    push(1, '0, 0, 0, 1, 0, 6);
    // auto-repeat, then release bounce
    push(2, K6, 0, 0, 0, 0, 6);
    push(1, K6, 1, 0, 0, 1, 6);
    push(5, K6, 0, 0, 0, 1, 6);
    push(1, K6, 1, 1, 0, 1, 6);
    for (int i = 0; i < 4; i++) begin
      push(1, K6, 0, 0, 0, 1, 6);
      push(1, K6, 1, 1, 0, 1, 6);
    end
    push(2, '0, 0, 0, 0, 1, 6);
    push(1, K6, 0, 0, 0, 1, 6);
    push(2, '0, 0, 0, 0, 1, 6);
    push(1, '0, 0, 0, 1, 0, 6);
    // ghosting and key change over a held key
    push(4, K05, 0, 0, 0, 0, 6);
    push(2, K6, 0, 0, 0, 0, 6);
    push(1, K6, 1, 0, 0, 1, 6);
    push(2, K69, 0, 0, 0, 1, 6);
    push(1, K69, 0, 0, 1, 0, 6);
    push(2, K9, 0, 0, 0, 0, 6);
    push(1, K9, 1, 0, 0, 1, 9);
    push(2, '0, 0, 0, 0, 1, 9);
    push(1, '0, 0, 0, 1, 0, 9);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst col", int'(col), 15);
    chk("rst outs", int'({key_valid, key_repeat, key_release, key_down}), 0);
    chk("rst code", int'(key_code), 0);

    // column walk
    rst = 1'b0;
    for (int n = 0; n < 32; n++) begin
      #1;
      chk($sformatf("scan col c%0d", n), int'(col),
          15 ^ (1 << ((n / 4) % 4)));
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // reset while a key is held
    t6.mask = K6; t6.v = 0; t6.rep = 0; t6.rel = 0;
    t6.down = 0; t6.code = 9;
    apply(t6, "pre6 a");
    apply(t6, "pre6 b");
    t6.v = 1; t6.down = 1; t6.code = 6;
    apply(t6, "pre6 press");
    nrel = 0;
    repeat (5) begin
      if (key_release) nrel++;
      @(negedge clk);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (key_release) nrel++;
      chk("rst6 col", int'(col), 15);
      chk("rst6 down", int'(key_down), 0);
      chk("rst6 code", int'(key_code), 0);
    end
    rst = 1'b0;
    repeat (2) begin
      if (key_release) nrel++;
      @(negedge clk);
    end
    chk("rst6 no release", nrel, 0);
    t6.v = 0; t6.down = 0; t6.code = 0;
    apply(t6, "post6 a");
    apply(t6, "post6 b");
    t6.v = 1; t6.down = 1; t6.code = 6;
    apply(t6, "post6 press");

    chk("pulse rules", n_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
